// File: rtl/regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// regfile_bypass_sb : ID-stage register file with write-back bypass and a
//                     per-register pending scoreboard that drives stall.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_bypass_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int INSTR_W   = 32,
  parameter int RS_LSB    = 21,
  parameter int RT_LSB    = 16,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] ifid_instr,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               sb_set,
  input  logic [ADDR_W-1:0]  sb_addr,
  output logic [ADDR_W-1:0]  rs,
  output logic [ADDR_W-1:0]  rt,
  output logic [DATA_W-1:0]  qa,
  output logic [DATA_W-1:0]  qb,
  output logic               stall
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG0 != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;

  logic byp_a;
  logic byp_b;
  logic zero_a;
  logic zero_b;
  logic unused_instr;

  assign rs = ifid_instr[RS_LSB +: ADDR_W];
  assign rt = ifid_instr[RT_LSB +: ADDR_W];
  assign unused_instr = ^ifid_instr;

  always_comb begin
    regs_d = regs_q;
    if (we && !(ZERO_EN && (waddr == '0))) begin
      regs_d[waddr] = wdata;
    end

    // A fresh issue outranks a retiring write: the new producer is still outstanding.
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_set && (sb_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (we && (waddr == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    if (ZERO_EN) begin
      pending_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign byp_a  = BYP_EN && we && (waddr == rs);
  assign byp_b  = BYP_EN && we && (waddr == rt);
  assign zero_a = ZERO_EN && (rs == '0);
  assign zero_b = ZERO_EN && (rt == '0);

  always_comb begin
    qa = regs_q[rs];
    if (byp_a) qa = wdata;
    if (zero_a) qa = '0;
    qb = regs_q[rt];
    if (byp_b) qb = wdata;
    if (zero_b) qb = '0;
  end

  // A bypassed operand is satisfied this cycle even though its pending bit is still set.
  assign stall = (pending_q[rs] && !byp_a && !zero_a) ||
                 (pending_q[rt] && !byp_b && !zero_b);

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass_sb : directed and random checks of regfile_bypass_sb,
//                        with and without bypass, against an array model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_bypass_sb;

  logic        clk;
  logic        rst_n;
  logic [31:0] ifid_instr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [4:0]  rs, rt, rs_nb, rt_nb;
  logic [31:0] qa, qb, qa_nb, qb_nb;
  logic        stall, stall_nb;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];

  regfile_bypass_sb dut (
    .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .we(we), .waddr(waddr),
    .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr), .rs(rs), .rt(rt),
    .qa(qa), .qb(qb), .stall(stall)
  );

  regfile_bypass_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .we(we), .waddr(waddr),
    .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr), .rs(rs_nb), .rt(rt_nb),
    .qa(qa_nb), .qb(qb_nb), .stall(stall_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] a, input logic [4:0] b);
    logic [31:0] v;
    v = $urandom;
    v[25:21] = a;
    v[20:16] = b;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit m_haz(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    return m_pend[a] && !(byp && we && waddr == a);
  endfunction

  task automatic idle();
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  // Advance one edge; the model applies the inputs that were present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 5'd0) m_mem[waddr] = wdata;
      if (we) m_pend[waddr] = 1'b0;
      if (sb_set) m_pend[sb_addr] = 1'b1;
      m_pend[0] = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0001;
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    idle();
    ifid_instr = mk_instr(5'd3, 5'd17);
    #1;
    checks++; if (qa !== 32'd0) begin errors++; $display("FAIL reset_qa: got %h want 0", qa); end
    checks++; if (qb !== 32'd0) begin errors++; $display("FAIL reset_qb: got %h want 0", qb); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle();
    ifid_instr = 32'h00A52000;
    #1;
    checks++; if (rs !== 5'd5 || rt !== 5'd5) begin errors++; $display("FAIL decode: got rs=%0d rt=%0d want 5 5", rs, rt); end
    checks++; if (qa !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_qa: got %h want deadbeef", qa); end
    checks++; if (qb !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_qb: got %h want deadbeef", qb); end
    checks++; if (qa_nb !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_qa_nobyp: got %h want deadbeef", qa_nb); end
  endtask

  task automatic test_bypass();
    ifid_instr = mk_instr(5'd7, 5'd5);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    #1;
    checks++; if (qa !== 32'h12345678) begin errors++; $display("FAIL bypass_qa: got %h want 12345678", qa); end
    checks++; if (qa_nb !== 32'd0) begin errors++; $display("FAIL nobypass_qa: got %h want 0", qa_nb); end
    checks++; if (qb !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_qb: got %h want deadbeef", qb); end
    tick();
    idle();
    #1;
    checks++; if (qa_nb !== 32'h12345678) begin errors++; $display("FAIL nobypass_after: got %h want 12345678", qa_nb); end
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    ifid_instr = mk_instr(5'd0, 5'd0);
    #1;
    checks++; if (qa !== 32'd0) begin errors++; $display("FAIL reg0_bypass_qa: got %h want 0", qa); end
    tick();
    idle();
    sb_set = 1'b1; sb_addr = 5'd0;
    #1;
    checks++; if (qa !== 32'd0 || qb !== 32'd0) begin errors++; $display("FAIL reg0_read: got qa=%h qb=%h want 0", qa, qb); end
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reg0_stall: got %b want 0", stall); end
  endtask

  task automatic test_scoreboard();
    ifid_instr = mk_instr(5'd1, 5'd2);
    sb_set = 1'b1; sb_addr = 5'd9;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_same_cycle: got %b want 0", stall); end
    tick();
    idle();
    ifid_instr = mk_instr(5'd1, 5'd9);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_pending: got %b want 1", stall); end
    tick();
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000999;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_wb_bypass: got %b want 0", stall); end
    checks++; if (stall_nb !== 1'b1) begin errors++; $display("FAIL sb_wb_nobypass: got %b want 1", stall_nb); end
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b0 || stall_nb !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b/%b want 0/0", stall, stall_nb); end
    sb_set = 1'b1; sb_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h0000ABCD;
    tick();
    idle();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", stall); end
    checks++; if (qb !== 32'h0000ABCD) begin errors++; $display("FAIL sb_set_wins_data: got %h want 0000abcd", qb); end
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000ABCE;
    tick();
    idle();
  endtask

  task automatic test_reset_midflight();
    sb_set = 1'b1; sb_addr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h000000AA;
    tick();
    idle();
    ifid_instr = mk_instr(5'd4, 5'd0);
    #1;
    checks++; if (qa_nb !== 32'h000000AA || stall !== 1'b1) begin errors++; $display("FAIL midflight_pre: got qa=%h stall=%b want aa 1", qa_nb, stall); end
    rst_n = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'h00000055;
    tick();
    idle();
    #1;
    checks++; if (qa !== 32'd0) begin errors++; $display("FAIL midflight_qa: got %h want 0", qa); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midflight_stall: got %b want 0", stall); end
  endtask

  task automatic test_random();
    logic [4:0] a, b;
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      we      = $urandom_range(0, 1);
      waddr   = 5'($urandom_range(0, 7));
      wdata   = $urandom;
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = 5'($urandom_range(0, 7));
      a = 5'($urandom_range(0, 7));
      b = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      ifid_instr = mk_instr(a, b);
      #1;
      checks++;
      if (qa !== m_read(a, 1'b1) || qb !== m_read(b, 1'b1)) begin
        errors++; $display("FAIL rand_q n=%0d: got %h %h want %h %h", n, qa, qb, m_read(a, 1'b1), m_read(b, 1'b1));
      end
      checks++;
      if (stall !== (m_haz(a, 1'b1) || m_haz(b, 1'b1))) begin
        errors++; $display("FAIL rand_stall n=%0d: got %b want %b", n, stall, m_haz(a, 1'b1) || m_haz(b, 1'b1));
      end
      checks++;
      if (qa_nb !== m_read(a, 1'b0) || qb_nb !== m_read(b, 1'b0) ||
          stall_nb !== (m_haz(a, 1'b0) || m_haz(b, 1'b0))) begin
        errors++; $display("FAIL rand_nobyp n=%0d: got %h %h %b want %h %h %b", n, qa_nb, qb_nb, stall_nb,
                           m_read(a, 1'b0), m_read(b, 1'b0), m_haz(a, 1'b0) || m_haz(b, 1'b0));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    idle();
    ifid_instr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_scoreboard();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
